// File: rtl/addr_gen_if.sv
// addr_gen_if: op handshake and address bus between the control FSM (master) and addr_gen_unit (slave)
interface addr_gen_if #(
    parameter int DATA_W = 8
);
    logic                  op_valid;
    logic [3:0]            op;
    logic                  op_ready;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     pcl;
    logic [DATA_W-1:0]     pch;
    logic [DATA_W-1:0]     idx;
    logic [1:0]            vec_sel;
    logic [2*DATA_W-1:0]   addr;
    logic                  busy;
    logic                  page_cross;
    modport master (
        output op_valid, op, data, pcl, pch, idx, vec_sel,
        input  op_ready, addr, busy, page_cross
    );
    modport slave (
        input  op_valid, op, data, pcl, pch, idx, vec_sel,
        output op_ready, addr, busy, page_cross
    );
endinterface

// File: rtl/addr_gen_unit.sv
// addr_gen_unit: 6502 {ABH,ABL} address register with indexed adds, page-cross fixup and vectors.
// Define ABR_PAGE_WRAP_BUG_EN to make INC_PTR wrap within the page (JMP ($xxFF) behaviour).
module addr_gen_unit #(
    parameter int                  DATA_W     = 8,
    parameter logic [DATA_W-1:0]   VEC_HI     = 8'hFF,
    parameter logic [2*DATA_W-1:0] RESET_ADDR = 16'h0000
) (
    input  logic clk,
    input  logic reset_l,
    addr_gen_if.slave bus
);
    localparam logic [3:0] OP_LOAD_PC  = 4'd1;
    localparam logic [3:0] OP_LOAD_ZP  = 4'd2;
    localparam logic [3:0] OP_LOAD_LO  = 4'd3;
    localparam logic [3:0] OP_LOAD_HI  = 4'd4;
    localparam logic [3:0] OP_INDEX_R  = 4'd5;
    localparam logic [3:0] OP_INDEX_W  = 4'd6;
    localparam logic [3:0] OP_INDEX_ZP = 4'd7;
    localparam logic [3:0] OP_INC      = 4'd8;
    localparam logic [3:0] OP_INC_PTR  = 4'd9;
    localparam logic [3:0] OP_VECTOR   = 4'd10;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FIXUP = 1'b1;

    logic [DATA_W-1:0]   r_abh;
    logic [DATA_W-1:0]   r_abl;
    logic [0:0]          r_state;
    logic                r_carry;
    logic                r_page_cross;

    logic                w_busy;
    logic                w_accept;
    logic [DATA_W:0]     w_sum;
    logic                w_carry;
    logic [2*DATA_W-1:0] w_inc;
    logic [2*DATA_W-1:0] w_inc_ptr;
    logic [1:0]          w_sel;
    logic [DATA_W-1:0]   w_vec_lo;
    logic [2*DATA_W-1:0] w_next;

    assign w_busy   = r_state == S_FIXUP;
    assign w_accept = bus.op_valid & ~w_busy;
    assign w_sum    = {1'b0, r_abl} + {1'b0, bus.idx};
    assign w_carry  = w_sum[DATA_W];
    assign w_inc    = {r_abh, r_abl} + 1'b1;
`ifdef ABR_PAGE_WRAP_BUG_EN
    assign w_inc_ptr = {r_abh, r_abl + 1'b1};
`else
    assign w_inc_ptr = w_inc;
`endif
    // vec_sel 3 aliases RESET
    assign w_sel    = (bus.vec_sel == 2'd3) ? 2'd1 : bus.vec_sel;
    assign w_vec_lo = DATA_W'(8'hFA) + DATA_W'({w_sel, 1'b0});

    always_comb begin
        w_next = {r_abh, r_abl};
        case (bus.op)
            OP_LOAD_PC:             w_next = {bus.pch, bus.pcl};
            OP_LOAD_ZP:             w_next = {{DATA_W{1'b0}}, bus.data};
            OP_LOAD_LO:             w_next = {r_abh, bus.data};
            OP_LOAD_HI:             w_next = {bus.data, r_abl};
            OP_INDEX_R, OP_INDEX_W: w_next = {r_abh, w_sum[DATA_W-1:0]};
            OP_INDEX_ZP:            w_next = {{DATA_W{1'b0}}, w_sum[DATA_W-1:0]};
            OP_INC:                 w_next = w_inc;
            OP_INC_PTR:             w_next = w_inc_ptr;
            OP_VECTOR:              w_next = {VEC_HI, w_vec_lo};
            default:                w_next = {r_abh, r_abl};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            {r_abh, r_abl} <= RESET_ADDR;
            r_state        <= S_IDLE;
            r_carry        <= 1'b0;
            r_page_cross   <= 1'b0;
        end else if (w_busy) begin
            r_abh        <= r_abh + DATA_W'(r_carry);
            r_state      <= S_IDLE;
            r_carry      <= 1'b0;
            r_page_cross <= 1'b0;
        end else begin
            if (w_accept)
                {r_abh, r_abl} <= w_next;
            // INDEX_W always pays the fixup cycle; INDEX_R only when ABL carries
            r_state      <= (w_accept & ((bus.op == OP_INDEX_R & w_carry) | bus.op == OP_INDEX_W)) ? S_FIXUP : S_IDLE;
            r_carry      <= w_accept & (bus.op == OP_INDEX_R | bus.op == OP_INDEX_W) & w_carry;
            r_page_cross <= w_accept & (bus.op == OP_INDEX_R | bus.op == OP_INDEX_W) & w_carry;
        end
    end

    assign bus.addr       = {r_abh, r_abl};
    assign bus.busy       = w_busy;
    assign bus.page_cross = r_page_cross;
    assign bus.op_ready   = ~w_busy & reset_l;
endmodule

// File: tb/tb_addr_gen_unit.sv
// tb_addr_gen_unit: directed vector table plus hand sequences for fixup, reset and held-op cases.
module tb_addr_gen_unit;
    logic clk = 1'b0;
    logic reset_l = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    addr_gen_if #(.DATA_W(8)) bus();
    addr_gen_unit dut (.clk(clk), .reset_l(reset_l), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  data;
        logic [7:0]  pch;
        logic [7:0]  pcl;
        logic [7:0]  idx;
        logic [1:0]  vec_sel;
        logic [15:0] exp_addr;
        logic        exp_pc;
    } vec_t;

`ifdef ABR_PAGE_WRAP_BUG_EN
    localparam logic [15:0] INC_PTR_EXP = 16'h1200;
`else
    localparam logic [15:0] INC_PTR_EXP = 16'h1300;
`endif

    vec_t tbl[20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] data, input logic [7:0] pch,
                         input logic [7:0] pcl, input logic [7:0] idx, input logic [1:0] vs);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op = op;
        bus.data = data;
        bus.pch = pch;
        bus.pcl = pcl;
        bus.idx = idx;
        bus.vec_sel = vs;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    task automatic load_pc(input logic [15:0] a);
        drive(4'd1, 8'h00, a[15:8], a[7:0], 8'h00, 2'd0);
    endtask

    initial begin
        bus.op_valid = 1'b0;
        bus.op = 4'd0;
        bus.data = 8'h00;
        bus.pch = 8'h00;
        bus.pcl = 8'h00;
        bus.idx = 8'h00;
        bus.vec_sel = 2'd0;
        tbl[0]  = '{4'd1,  8'h00, 8'h12, 8'h34, 8'h00, 2'd0, 16'h1234, 1'b0};
        tbl[1]  = '{4'd3,  8'h56, 8'h00, 8'h00, 8'h00, 2'd0, 16'h1256, 1'b0};
        tbl[2]  = '{4'd4,  8'hAB, 8'h00, 8'h00, 8'h00, 2'd0, 16'hAB56, 1'b0};
        tbl[3]  = '{4'd0,  8'h11, 8'h22, 8'h33, 8'h44, 2'd0, 16'hAB56, 1'b0};
        tbl[4]  = '{4'd13, 8'h11, 8'h22, 8'h33, 8'h44, 2'd0, 16'hAB56, 1'b0};
        tbl[5]  = '{4'd2,  8'h80, 8'h77, 8'h66, 8'h00, 2'd0, 16'h0080, 1'b0};
        tbl[6]  = '{4'd7,  8'h00, 8'h00, 8'h00, 8'h90, 2'd0, 16'h0010, 1'b0};
        tbl[7]  = '{4'd5,  8'h00, 8'h00, 8'h00, 8'h05, 2'd0, 16'h0015, 1'b0};
        tbl[8]  = '{4'd8,  8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 16'h0016, 1'b0};
        tbl[9]  = '{4'd1,  8'h00, 8'hFF, 8'hFF, 8'h00, 2'd0, 16'hFFFF, 1'b0};
        tbl[10] = '{4'd8,  8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 16'h0000, 1'b0};
        tbl[11] = '{4'd10, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 16'hFFFA, 1'b0};
        tbl[12] = '{4'd10, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1, 16'hFFFC, 1'b0};
        tbl[13] = '{4'd10, 8'h00, 8'h00, 8'h00, 8'h00, 2'd2, 16'hFFFE, 1'b0};
        tbl[14] = '{4'd10, 8'h00, 8'h00, 8'h00, 8'h00, 2'd3, 16'hFFFC, 1'b0};
        tbl[15] = '{4'd1,  8'h00, 8'h12, 8'hFE, 8'h00, 2'd0, 16'h12FE, 1'b0};
        tbl[16] = '{4'd9,  8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 16'h12FF, 1'b0};
        tbl[17] = '{4'd9,  8'h00, 8'h00, 8'h00, 8'h00, 2'd0, INC_PTR_EXP, 1'b0};
        tbl[18] = '{4'd2,  8'hF0, 8'h00, 8'h00, 8'h00, 2'd0, 16'h00F0, 1'b0};
        tbl[19] = '{4'd7,  8'h00, 8'h00, 8'h00, 8'h20, 2'd0, 16'h0010, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr", bus.addr, 16'h0000);
        chk("reset_busy", {15'd0, bus.busy}, 16'd0);
        chk("reset_pc", {15'd0, bus.page_cross}, 16'd0);
        chk("reset_ready_low", {15'd0, bus.op_ready}, 16'd0);
        @(negedge clk) reset_l = 1'b1;
        #1 chk("ready_after_release", {15'd0, bus.op_ready}, 16'd1);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].op, tbl[i].data, tbl[i].pch, tbl[i].pcl, tbl[i].idx, tbl[i].vec_sel);
            chk($sformatf("vec%0d_addr", i), bus.addr, tbl[i].exp_addr);
            chk($sformatf("vec%0d_pc", i), {15'd0, bus.page_cross}, {15'd0, tbl[i].exp_pc});
            chk($sformatf("vec%0d_busy", i), {15'd0, bus.busy}, 16'd0);
        end

        // INDEX_R with carry, plus an op offered during busy that must be ignored
        load_pc(16'h12F0);
        drive(4'd5, 8'h00, 8'h00, 8'h00, 8'h20, 2'd0);
        chk("ixr_c_addr", bus.addr, 16'h1210);
        chk("ixr_c_pc", {15'd0, bus.page_cross}, 16'd1);
        chk("ixr_c_busy", {15'd0, bus.busy}, 16'd1);
        chk("ixr_c_ready", {15'd0, bus.op_ready}, 16'd0);
        bus.op_valid = 1'b1;
        bus.op = 4'd1;
        bus.pch = 8'h00;
        bus.pcl = 8'h00;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        chk("ixr_fix_addr", bus.addr, 16'h1310);
        chk("ixr_fix_pc", {15'd0, bus.page_cross}, 16'd0);
        chk("ixr_fix_busy", {15'd0, bus.busy}, 16'd0);
        @(posedge clk);
        #1 chk("held_op_ignored", bus.addr, 16'h1310);

        // INDEX_W without carry still costs a fixup cycle
        load_pc(16'h1210);
        drive(4'd6, 8'h00, 8'h00, 8'h00, 8'h05, 2'd0);
        chk("ixw_nc_addr", bus.addr, 16'h1215);
        chk("ixw_nc_pc", {15'd0, bus.page_cross}, 16'd0);
        chk("ixw_nc_busy", {15'd0, bus.busy}, 16'd1);
        @(posedge clk);
        #1 chk("ixw_nc_fix_addr", bus.addr, 16'h1215);
        chk("ixw_nc_fix_busy", {15'd0, bus.busy}, 16'd0);

        // INDEX_W with carry
        load_pc(16'h12F0);
        drive(4'd6, 8'h00, 8'h00, 8'h00, 8'h20, 2'd0);
        chk("ixw_c_addr", bus.addr, 16'h1210);
        chk("ixw_c_pc", {15'd0, bus.page_cross}, 16'd1);
        chk("ixw_c_busy", {15'd0, bus.busy}, 16'd1);
        @(posedge clk);
        #1 chk("ixw_c_fix_addr", bus.addr, 16'h1310);
        chk("ixw_c_fix_pc", {15'd0, bus.page_cross}, 16'd0);

        // ABH wraps FF->00 in the fixup cycle
        load_pc(16'hFFFF);
        drive(4'd5, 8'h00, 8'h00, 8'h00, 8'h01, 2'd0);
        chk("wrap_addr", bus.addr, 16'hFF00);
        chk("wrap_pc", {15'd0, bus.page_cross}, 16'd1);
        @(posedge clk);
        #1 chk("wrap_fix_addr", bus.addr, 16'h0000);

        // INDEX_R without carry is single-cycle
        load_pc(16'h1210);
        drive(4'd5, 8'h00, 8'h00, 8'h00, 8'h05, 2'd0);
        chk("ixr_nc_addr", bus.addr, 16'h1215);
        chk("ixr_nc_busy", {15'd0, bus.busy}, 16'd0);
        chk("ixr_nc_pc", {15'd0, bus.page_cross}, 16'd0);

        // reset in the middle of a fixup
        load_pc(16'h12F0);
        drive(4'd5, 8'h00, 8'h00, 8'h00, 8'h20, 2'd0);
        chk("pre_rst_busy", {15'd0, bus.busy}, 16'd1);
        reset_l = 1'b0;
        @(posedge clk);
        #1 chk("midfix_rst_addr", bus.addr, 16'h0000);
        chk("midfix_rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("midfix_rst_pc", {15'd0, bus.page_cross}, 16'd0);
        chk("midfix_rst_ready", {15'd0, bus.op_ready}, 16'd0);
        reset_l = 1'b1;
        #1 chk("midfix_ready_release", {15'd0, bus.op_ready}, 16'd1);
        @(posedge clk);
        #1 chk("midfix_no_resume", bus.addr, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
